// File: rtl/hazard_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_unit.
// master = pipeline side, slave = hazard_unit side.
interface hazard_if;
   logic       mem_read_id_ex;
   logic [4:0] rt_id_ex;
   logic [4:0] rs_if_id;
   logic [4:0] rt_if_id;
   logic       uses_rt_if_id;
   logic       branch_taken_ex;
   logic       mdu_start_ex;
   logic       pc_write;
   logic       if_id_write;
   logic       id_ex_write;
   logic       if_id_flush;
   logic       id_ex_bubble;
   logic       ex_mem_bubble;
   logic       busy;

   modport master (
      output mem_read_id_ex, rt_id_ex, rs_if_id, rt_if_id, uses_rt_if_id,
             branch_taken_ex, mdu_start_ex,
      input  pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble,
             ex_mem_bubble, busy
   );

   modport slave (
      input  mem_read_id_ex, rt_id_ex, rs_if_id, rt_if_id, uses_rt_if_id,
             branch_taken_ex, mdu_start_ex,
      output pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble,
             ex_mem_bubble, busy
   );
endinterface

// File: rtl/hazard_unit.sv
// Load-use / branch-flush / MDU-hold controller for the 5-stage pipeline.
// Optional HAZARD_STATS_EN adds saturating stall and flush counters.
module hazard_unit #(
   parameter int unsigned MDU_LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   hazard_if.slave     hz
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_count
`endif
);

   localparam int unsigned CntW = $clog2(MDU_LATENCY);
   localparam logic [CntW-1:0] CntInit = CntW'(MDU_LATENCY - 2);

   typedef enum logic [0:0] {StRun, StMduWait} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            load_use;

   assign load_use = hz.mem_read_id_ex && (hz.rt_id_ex != 5'd0) &&
                     ((hz.rt_id_ex == hz.rs_if_id) ||
                      (hz.uses_rt_if_id && (hz.rt_id_ex == hz.rt_if_id)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      hz.pc_write      = 1'b1;
      hz.if_id_write   = 1'b1;
      hz.id_ex_write   = 1'b1;
      hz.if_id_flush   = 1'b0;
      hz.id_ex_bubble  = 1'b0;
      hz.ex_mem_bubble = 1'b0;
      hz.busy          = (state_q == StMduWait);

      // Branch and load-use share the same handling in RUN and in the release cycle.
      if ((state_q == StRun) && !hz.branch_taken_ex && hz.mdu_start_ex) begin
         hz.pc_write      = 1'b0;
         hz.if_id_write   = 1'b0;
         hz.id_ex_write   = 1'b0;
         hz.ex_mem_bubble = 1'b1;
         state_d          = StMduWait;
         cnt_d            = CntInit;
      end else if ((state_q == StMduWait) && (cnt_q != '0)) begin
         hz.pc_write      = 1'b0;
         hz.if_id_write   = 1'b0;
         hz.id_ex_write   = 1'b0;
         hz.ex_mem_bubble = 1'b1;
         cnt_d            = cnt_q - CntW'(1);
      end else begin
         state_d = StRun;
         if (hz.branch_taken_ex) begin
            hz.if_id_flush  = 1'b1;
            hz.id_ex_bubble = 1'b1;
         end else if (load_use) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.id_ex_bubble = 1'b1;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!hz.pc_write && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
         end
         if (hz.if_id_flush && (flush_count != 16'hFFFF)) begin
            flush_count <= flush_count + 16'd1;
         end
      end
   end
`endif

endmodule
